// File: rtl/addsub_pipe.sv
// addsub_pipe: two-stage pipelined adder/subtractor with status flags.
//
// Stage 1 registers the operand pair and operation. Stage 2 computes the
// WIDTH+1-bit sum/difference and registers the result and flags. A
// valid/ready handshake sits on each side, and backpressure propagates
// combinationally from out_ready to in_ready.
//
// Parameters:
//   WIDTH  - operand/result width in bits (>= 2)
//   SIGNED - 1: saturation bounds and neg use two's complement; 0: unsigned
//
// Optional feature macro: ADDSUB_SATURATE_EN
//   When defined, an out-of-range result is clamped to the bound. The carry
//   and overflow flags still report the unclamped condition.
//   When undefined, the result wraps modulo 2^WIDTH.
//
// Ports:
//   clk       - rising-edge clock
//   rst_n     - synchronous reset, active-low
//   in_valid  - operand pair present
//   in_ready  - block accepts operands this cycle
//   a, b      - operands
//   sub       - 0: add, 1: subtract
//   cin       - carry-in (add) / borrow-in (sub)
//   out_valid - result present
//   out_ready - consumer accepts result this cycle
//   result    - sum/difference
//   carry     - carry-out (add) / borrow-out (sub)
//   overflow  - signed overflow
//   zero      - result == 0
//   neg       - result MSB (0 when SIGNED=0)
module addsub_pipe #(
  parameter int unsigned WIDTH  = 8,
  parameter bit          SIGNED = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             neg
);

  localparam int unsigned Msb = WIDTH - 1;

  // Stage 1 registers
  logic             v1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             sub1;
  logic             cin1;

  // Stage 2 valid; data lives directly in the output registers
  logic v2;

  logic adv1;
  logic adv2;

  assign adv2      = !v2 || out_ready;
  assign adv1      = !v1 || adv2;
  assign in_ready  = adv1;
  assign out_valid = v2;

  // Stage 2 combinational arithmetic
  logic [WIDTH:0]   s;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH-1:0] res_c;
  logic             carry_c;
  logic             ovf_c;
  logic             zero_c;
  logic             neg_c;

  always_comb begin
    // Subtract is a + ~b + 1, and a borrow-in removes that +1.
    b_op    = sub1 ? ~b1 : b1;
    s       = {1'b0, a1} + {1'b0, b_op} + {{WIDTH{1'b0}}, (sub1 ? ~cin1 : cin1)};
    carry_c = sub1 ? ~s[WIDTH] : s[WIDTH];
    if (sub1) begin
      ovf_c = (a1[Msb] != b1[Msb]) && (s[Msb] != a1[Msb]);
    end else begin
      ovf_c = (a1[Msb] == b1[Msb]) && (s[Msb] != a1[Msb]);
    end
    res_c = s[WIDTH-1:0];
`ifdef ADDSUB_SATURATE_EN
    if (SIGNED) begin
      // Clamp toward the sign of A: positive A can only overflow upward.
      if (ovf_c) begin
        res_c = a1[Msb] ? {1'b1, {(WIDTH - 1){1'b0}}} : {1'b0, {(WIDTH - 1){1'b1}}};
      end
    end else if (carry_c) begin
      res_c = sub1 ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
    end
`endif
    zero_c = (res_c == {WIDTH{1'b0}});
    neg_c  = SIGNED ? res_c[Msb] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1       <= 1'b0;
      a1       <= '0;
      b1       <= '0;
      sub1     <= 1'b0;
      cin1     <= 1'b0;
      v2       <= 1'b0;
      result   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      neg      <= 1'b0;
    end else begin
      if (adv1) begin
        v1 <= in_valid;
        if (in_valid) begin
          a1   <= a;
          b1   <= b;
          sub1 <= sub;
          cin1 <= cin;
        end
      end
      // Outputs only change when stage 2 advances, so they hold under stall.
      if (adv2) begin
        v2 <= v1;
        if (v1) begin
          result   <= res_c;
          carry    <= carry_c;
          overflow <= ovf_c;
          zero     <= zero_c;
          neg      <= neg_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: self-checking bench for addsub_pipe at WIDTH=4, SIGNED=1.
// Directed vectors, backpressure, reset mid-stream and random traffic are
// checked against an integer-arithmetic reference model and a FIFO of
// expected results.
module tb_addsub_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic       sub;
  logic       cin;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] result;
  logic       carry;
  logic       overflow;
  logic       zero;
  logic       neg;

  addsub_pipe #(
    .WIDTH (4),
    .SIGNED(1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .sub      (sub),
    .cin      (cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .carry    (carry),
    .overflow (overflow),
    .zero     (zero),
    .neg      (neg)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  int         n_out = 0;
  logic [7:0] exp_q[$];
  logic       last_in_fire = 1'b0;
  logic       stall_prev = 1'b0;
  logic [7:0] held = '0;

  // Reference: {result[3:0], carry, overflow, zero, neg}
  function automatic logic [7:0] model(input logic [3:0] ma, input logic [3:0] mb,
                                       input logic msub, input logic mcin);
    int         ua;
    int         ub;
    int         sa;
    int         sb;
    int         u;
    int         t;
    logic [3:0] r;
    logic       c;
    logic       o;
    ua = int'(ma);
    ub = int'(mb);
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    if (!msub) begin
      u = ua + ub + int'(mcin);
      t = sa + sb + int'(mcin);
      c = (u > 15);
    end else begin
      u = ua - ub - int'(mcin);
      t = sa - sb - int'(mcin);
      c = (u < 0);
    end
    r = 4'(u & 15);
    o = (t > 7) || (t < -8);
`ifdef ADDSUB_SATURATE_EN
    if (o) r = (sa >= 0) ? 4'd7 : 4'd8;
`endif
    return {r, c, o, (r == 4'd0), r[3]};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic randomize_ops();
    a   = 4'($urandom_range(0, 15));
    b   = 4'($urandom_range(0, 15));
    sub = 1'($urandom_range(0, 1));
    cin = 1'($urandom_range(0, 1));
  endtask

  // One clock: sample at negedge, score transfers, advance past posedge.
  task automatic tick();
    logic [7:0] cur;
    @(negedge clk);
    cur = {result, carry, overflow, zero, neg};
    if (stall_prev) check("hold_stable", {7'd0, out_valid, cur}, {7'd0, 1'b1, held});
    last_in_fire = 1'b0;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) check("spurious_output", 16'(out_valid), 16'd0);
        else check("result_vs_model", 16'(cur), 16'(exp_q.pop_front()));
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, sub, cin));
        last_in_fire = 1'b1;
      end
    end
    stall_prev = rst_n && out_valid && !out_ready;
    held = cur;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end
  endtask

  task automatic directed(input string tag, input logic [3:0] da, input logic [3:0] db,
                          input logic dsub, input logic dcin, input logic [7:0] exp);
    a = da; b = db; sub = dsub; cin = dcin;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, "_lat1"}, 16'(out_valid), 16'd0);
    tick();
    check({tag, "_lat2"}, 16'(out_valid), 16'd1);
    check(tag, 16'({result, carry, overflow, zero, neg}), 16'(exp));
    tick();
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick();
    check("drain_empty", 16'(exp_q.size()), 16'd0);
  endtask

  task automatic rand_traffic(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      randomize_ops();
      tick();
    end
  endtask

  initial begin
    int acc;
    int out_before;

    // Reset held 3 cycles with in_valid asserted
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    randomize_ops();
    for (int i = 0; i < 3; i++) tick();
    check("reset_outputs", {7'd0, out_valid, result, carry, overflow, zero, neg}, 16'd0);
    rst_n = 1'b1; in_valid = 1'b0;
    check("reset_in_ready", 16'(in_ready), 16'd1);
    for (int i = 0; i < 3; i++) tick();
    check("no_out_after_reset", 16'(out_valid), 16'd0);
    check("no_out_count", 16'(n_out), 16'd0);

`ifdef ADDSUB_SATURATE_EN
    directed("add_6_3", 4'd6, 4'd3, 1'b0, 1'b0, {4'b0111, 1'b0, 1'b1, 1'b0, 1'b0});
    directed("sub_8_2", 4'b1000, 4'b0010, 1'b1, 1'b0, {4'b1000, 1'b0, 1'b1, 1'b0, 1'b1});
`else
    directed("add_6_3", 4'd6, 4'd3, 1'b0, 1'b0, {4'b1001, 1'b0, 1'b1, 1'b0, 1'b1});
    directed("sub_8_2", 4'b1000, 4'b0010, 1'b1, 1'b0, {4'b0110, 1'b0, 1'b1, 1'b0, 1'b0});
`endif
    directed("sub_1_1_b", 4'd1, 4'd1, 1'b1, 1'b1, {4'b1111, 1'b1, 1'b0, 1'b0, 1'b1});
    directed("add_1_15", 4'd1, 4'd15, 1'b0, 1'b0, {4'b0000, 1'b1, 1'b0, 1'b1, 1'b0});

    // Backpressure: 4 ops with consumer stalled
    out_before = n_out;
    acc = 0;
    out_ready = 1'b0; in_valid = 1'b1;
    randomize_ops();
    for (int i = 0; i < 5; i++) begin
      tick();
      if (last_in_fire) begin acc++; randomize_ops(); end
    end
    check("bp_accepted", 16'(acc), 16'd2);
    check("bp_in_ready", 16'(in_ready), 16'd0);
    check("bp_out_valid", 16'(out_valid), 16'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 10 && acc < 4; i++) begin
      tick();
      if (last_in_fire) begin acc++; randomize_ops(); end
    end
    check("bp_total_in", 16'(acc), 16'd4);
    drain();
    check("bp_total_out", 16'(n_out - out_before), 16'd4);

    rand_traffic(300);
    drain();

    // Reset with a full, stalled pipeline
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin randomize_ops(); tick(); end
    check("full_before_reset", 16'(out_valid), 16'd1);
    rst_n = 1'b0;
    tick();
    check("midreset_outputs", {7'd0, out_valid, result, carry, overflow, zero, neg}, 16'd0);
    rst_n = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1;
    check("midreset_in_ready", 16'(in_ready), 16'd1);
    tick();
    check("midreset_no_out", 16'(out_valid), 16'd0);
    rand_traffic(100);
    drain();
    check("final_idle", 16'(out_valid), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
